// File: rtl/ex_operand_fwd_pkg.sv
// Shared types and helpers for the EX-stage operand forwarding slice.
package ex_operand_fwd_pkg;

   localparam int DATA_W = 32;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } fwd_state_e;

   typedef enum logic [1:0] {
      SRC_MA    = 2'd0,
      SRC_WB    = 2'd1,
      SRC_WBDLY = 2'd2,
      SRC_RF    = 2'd3
   } fwd_src_e;

   // A load-use bubble must never see forwarded data; otherwise youngest producer wins.
   function automatic fwd_src_e fwd_src_pick(input logic stall_ld, input logic idex,
                                             input logic idma, input logic idwb);
      fwd_src_e src;
      if (stall_ld)  src = SRC_RF;
      else if (idex) src = SRC_MA;
      else if (idma) src = SRC_WB;
      else if (idwb) src = SRC_WBDLY;
      else           src = SRC_RF;
      return src;
   endfunction

   function automatic logic fwd_flags_bad(input logic idex, input logic idma,
                                          input logic idwb, input logic nohit);
      logic [2:0] cnt;
      cnt = {2'b00, idex} + {2'b00, idma} + {2'b00, idwb} + {2'b00, nohit};
      return (cnt > 3'd1);
   endfunction

endpackage

// File: rtl/ex_operand_fwd_fwd_sel_mux.sv
// Per-operand forwarding mux: hit flags pick one of four 32-bit sources.
module fwd_sel_mux
   import ex_operand_fwd_pkg::*;
(
   input  logic              stall_ld_i,
   input  logic              hit_idex_i,
   input  logic              hit_idma_i,
   input  logic              hit_idwb_i,
   input  logic [DATA_W-1:0] src_ma_i,
   input  logic [DATA_W-1:0] src_wb_i,
   input  logic [DATA_W-1:0] src_wbdly_i,
   input  logic [DATA_W-1:0] src_rf_i,
   output logic [DATA_W-1:0] opnd_o
);

   fwd_src_e src_s;

   // Source selection and data steering.
   always_comb begin
      src_s  = fwd_src_pick(stall_ld_i, hit_idex_i, hit_idma_i, hit_idwb_i);
      opnd_o = src_rf_i;
      case (src_s)
         SRC_MA:    opnd_o = src_ma_i;
         SRC_WB:    opnd_o = src_wb_i;
         SRC_WBDLY: opnd_o = src_wbdly_i;
         SRC_RF:    opnd_o = src_rf_i;
         default:   opnd_o = src_rf_i;
      endcase
   end

endmodule

// File: rtl/ex_operand_fwd.sv
// EX operand forwarding with stall hold registers.
// Optional flag-consistency checker enabled by `define FWD_ONEHOT_CHK_EN.
module ex_operand_fwd
   import ex_operand_fwd_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hit_rs1_idex_ex,
   input  logic              hit_rs1_idma_ex,
   input  logic              hit_rs1_idwb_ex,
   input  logic              nohit_rs1_ex,
   input  logic              hit_rs2_idex_ex,
   input  logic              hit_rs2_idma_ex,
   input  logic              hit_rs2_idwb_ex,
   input  logic              nohit_rs2_ex,
   input  logic              stall_ld_ex,
   input  logic              stall,
   input  logic              rst_pipe,
   input  logic [DATA_W-1:0] rs1_data_ex,
   input  logic [DATA_W-1:0] rs2_data_ex,
   input  logic [DATA_W-1:0] rd_data_ma,
   input  logic [DATA_W-1:0] rd_data_wb,
   output logic [DATA_W-1:0] rs1_fwd_ex,
   output logic [DATA_W-1:0] rs2_fwd_ex,
   output logic              fwd_hold,
   output logic              fwd_err
);

   fwd_state_e        state_q, state_d;
   logic [DATA_W-1:0] wb_dly_q, wb_dly_d;
   logic [DATA_W-1:0] rs1_hold_q, rs1_hold_d;
   logic [DATA_W-1:0] rs2_hold_q, rs2_hold_d;
   logic [DATA_W-1:0] rs1_sel_s, rs2_sel_s;

   fwd_sel_mux u_rs1_mux (
      .stall_ld_i  (stall_ld_ex),
      .hit_idex_i  (hit_rs1_idex_ex),
      .hit_idma_i  (hit_rs1_idma_ex),
      .hit_idwb_i  (hit_rs1_idwb_ex),
      .src_ma_i    (rd_data_ma),
      .src_wb_i    (rd_data_wb),
      .src_wbdly_i (wb_dly_q),
      .src_rf_i    (rs1_data_ex),
      .opnd_o      (rs1_sel_s)
   );

   fwd_sel_mux u_rs2_mux (
      .stall_ld_i  (stall_ld_ex),
      .hit_idex_i  (hit_rs2_idex_ex),
      .hit_idma_i  (hit_rs2_idma_ex),
      .hit_idwb_i  (hit_rs2_idwb_ex),
      .src_ma_i    (rd_data_ma),
      .src_wb_i    (rd_data_wb),
      .src_wbdly_i (wb_dly_q),
      .src_rf_i    (rs2_data_ex),
      .opnd_o      (rs2_sel_s)
   );

   // State register, delayed writeback data and hold registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         wb_dly_q   <= {DATA_W{1'b0}};
         rs1_hold_q <= {DATA_W{1'b0}};
         rs2_hold_q <= {DATA_W{1'b0}};
      end else begin
         state_q    <= state_d;
         wb_dly_q   <= wb_dly_d;
         rs1_hold_q <= rs1_hold_d;
         rs2_hold_q <= rs2_hold_d;
      end
   end

   // Next-state logic; a flush always wins over a freeze.
   always_comb begin
      state_d    = state_q;
      wb_dly_d   = wb_dly_q;
      rs1_hold_d = rs1_hold_q;
      rs2_hold_d = rs2_hold_q;
      if (rst_pipe) begin
         state_d    = ST_RUN;
         wb_dly_d   = {DATA_W{1'b0}};
         rs1_hold_d = {DATA_W{1'b0}};
         rs2_hold_d = {DATA_W{1'b0}};
      end else begin
         case (state_q)
            ST_RUN:  state_d = stall ? ST_HOLD : ST_RUN;
            ST_HOLD: state_d = stall ? ST_HOLD : ST_RUN;
            default: state_d = ST_RUN;
         endcase
         if (!stall) begin
            wb_dly_d = rd_data_wb;
         end else begin
            wb_dly_d = wb_dly_q;
         end
         // Operands are snapshotted only on the edge entering the freeze.
         if ((state_q == ST_RUN) && stall) begin
            rs1_hold_d = rs1_sel_s;
            rs2_hold_d = rs2_sel_s;
         end else begin
            rs1_hold_d = rs1_hold_q;
            rs2_hold_d = rs2_hold_q;
         end
      end
   end

   // Output steering: live select in RUN, frozen snapshot in HOLD.
   always_comb begin
      rs1_fwd_ex = rs1_sel_s;
      rs2_fwd_ex = rs2_sel_s;
      fwd_hold   = 1'b0;
      case (state_q)
         ST_RUN: begin
            rs1_fwd_ex = rs1_sel_s;
            rs2_fwd_ex = rs2_sel_s;
            fwd_hold   = 1'b0;
         end
         ST_HOLD: begin
            rs1_fwd_ex = rs1_hold_q;
            rs2_fwd_ex = rs2_hold_q;
            fwd_hold   = 1'b1;
         end
         default: begin
            rs1_fwd_ex = rs1_sel_s;
            rs2_fwd_ex = rs2_sel_s;
            fwd_hold   = 1'b0;
         end
      endcase
   end

`ifdef FWD_ONEHOT_CHK_EN
   logic err_q, err_d;

   // Sticky error: only a hard reset clears it.
   always_comb begin
      if (fwd_flags_bad(hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex, nohit_rs1_ex) ||
          fwd_flags_bad(hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, nohit_rs2_ex)) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Error flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign fwd_err = err_q;
`else
   logic unused_s;
   assign unused_s = ^{nohit_rs1_ex, nohit_rs2_ex};
   assign fwd_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ex_operand_fwd.sv
// Self-checking bench for ex_operand_fwd: directed scenarios plus randomized traffic vs. a reference model.
module tb_ex_operand_fwd;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        h1_idex, h1_idma, h1_idwb, n1;
   logic        h2_idex, h2_idma, h2_idwb, n2;
   logic        stall_ld, stall, rst_pipe;
   logic [31:0] rs1_data, rs2_data, rd_ma, rd_wb;
   logic [31:0] rs1_fwd, rs2_fwd;
   logic        fwd_hold, fwd_err;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: frozen flag, snapshots, last unstalled WB value, sticky error.
   logic        m_hold;
   logic [31:0] m_h1, m_h2, m_wbdly;
   logic        m_err;

   always #5 clk = ~clk;

   ex_operand_fwd dut (
      .clk(clk), .rst_n(rst_n),
      .hit_rs1_idex_ex(h1_idex), .hit_rs1_idma_ex(h1_idma), .hit_rs1_idwb_ex(h1_idwb), .nohit_rs1_ex(n1),
      .hit_rs2_idex_ex(h2_idex), .hit_rs2_idma_ex(h2_idma), .hit_rs2_idwb_ex(h2_idwb), .nohit_rs2_ex(n2),
      .stall_ld_ex(stall_ld), .stall(stall), .rst_pipe(rst_pipe),
      .rs1_data_ex(rs1_data), .rs2_data_ex(rs2_data), .rd_data_ma(rd_ma), .rd_data_wb(rd_wb),
      .rs1_fwd_ex(rs1_fwd), .rs2_fwd_ex(rs2_fwd), .fwd_hold(fwd_hold), .fwd_err(fwd_err)
   );

   function automatic logic [31:0] pick(input logic idex, input logic idma, input logic idwb,
                                        input logic [31:0] rf);
      if (stall_ld)  return rf;
      if (idex)      return rd_ma;
      if (idma)      return rd_wb;
      if (idwb)      return m_wbdly;
      return rf;
   endfunction

   function automatic logic [31:0] exp1();
      return m_hold ? m_h1 : pick(h1_idex, h1_idma, h1_idwb, rs1_data);
   endfunction

   function automatic logic [31:0] exp2();
      return m_hold ? m_h2 : pick(h2_idex, h2_idma, h2_idwb, rs2_data);
   endfunction

   task automatic model_reset();
      m_hold = 1'b0; m_h1 = 32'h0; m_h2 = 32'h0; m_wbdly = 32'h0; m_err = 1'b0;
   endtask

   task automatic idle();
      {h1_idex, h1_idma, h1_idwb, n1} = 4'b0000;
      {h2_idex, h2_idma, h2_idwb, n2} = 4'b0000;
      stall_ld = 1'b0; stall = 1'b0; rst_pipe = 1'b0;
      rs1_data = 32'hA1A1_0001; rs2_data = 32'hB2B2_0002;
      rd_ma = 32'hCCCC_0003; rd_wb = 32'hDDDD_0004;
   endtask

   // Advance one clock edge, updating the model from the inputs seen at that edge.
   task automatic tick();
      logic [31:0] l1, l2;
      l1 = pick(h1_idex, h1_idma, h1_idwb, rs1_data);
      l2 = pick(h2_idex, h2_idma, h2_idwb, rs2_data);
`ifdef FWD_ONEHOT_CHK_EN
      if ($countones({h1_idex, h1_idma, h1_idwb, n1}) > 1 ||
          $countones({h2_idex, h2_idma, h2_idwb, n2}) > 1) m_err = 1'b1;
`endif
      if (rst_pipe) begin
         m_hold = 1'b0; m_h1 = 32'h0; m_h2 = 32'h0; m_wbdly = 32'h0;
      end else begin
         if (!m_hold && stall) begin
            m_h1 = l1; m_h2 = l2;
         end
         m_hold = stall;
         if (!stall) m_wbdly = rd_wb;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      n_cmp++; if (rs1_fwd !== rs1_data) begin n_bad++; $display("FAIL reset_rs1 got %h exp %h", rs1_fwd, rs1_data); end
      n_cmp++; if (rs2_fwd !== rs2_data) begin n_bad++; $display("FAIL reset_rs2 got %h exp %h", rs2_fwd, rs2_data); end
      n_cmp++; if (fwd_hold !== 1'b0) begin n_bad++; $display("FAIL reset_hold got %b exp 0", fwd_hold); end
      n_cmp++; if (fwd_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", fwd_err); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      // Freeze, then drop reset asynchronously mid-cycle.
      stall = 1'b1;
      tick();
      n_cmp++; if (fwd_hold !== 1'b1) begin n_bad++; $display("FAIL pre_async_hold got %b exp 1", fwd_hold); end
      rs1_data = 32'h1234_5678;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_cmp++; if (fwd_hold !== 1'b0) begin n_bad++; $display("FAIL async_rst_hold got %b exp 0", fwd_hold); end
      n_cmp++; if (rs1_fwd !== 32'h1234_5678) begin n_bad++; $display("FAIL async_rst_rs1 got %h exp 12345678", rs1_fwd); end
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      tick();
   endtask

   task automatic test_directed();
      idle();
      // Same-cycle forward from MA.
      h1_idex = 1'b1; rd_ma = 32'h11; rs1_data = 32'h99;
      @(negedge clk);
      n_cmp++; if (rs1_fwd !== 32'h11) begin n_bad++; $display("FAIL fwd_ma got %h exp 11", rs1_fwd); end
      tick();
      // Delayed WB path.
      idle(); rd_wb = 32'h22;
      tick();
      h2_idwb = 1'b1; rd_wb = 32'h77;
      @(negedge clk);
      n_cmp++; if (rs2_fwd !== 32'h22) begin n_bad++; $display("FAIL fwd_wbdly got %h exp 22", rs2_fwd); end
      n_cmp++; if (rs1_fwd !== rs1_data) begin n_bad++; $display("FAIL fwd_rf_idle got %h exp %h", rs1_fwd, rs1_data); end
      tick();
      // Three-cycle stall while WB data moves on.
      idle(); h1_idma = 1'b1; rd_wb = 32'h33; stall = 1'b1;
      @(negedge clk);
      n_cmp++; if (rs1_fwd !== 32'h33 || fwd_hold !== 1'b0) begin n_bad++; $display("FAIL stall_c0 got %h/%b exp 33/0", rs1_fwd, fwd_hold); end
      tick();
      rd_wb = 32'h44;
      for (int i = 1; i < 4; i++) begin
         if (i == 3) stall = 1'b0;
         @(negedge clk);
         n_cmp++; if (rs1_fwd !== 32'h33 || fwd_hold !== 1'b1) begin n_bad++; $display("FAIL stall_c%0d got %h/%b exp 33/1", i, rs1_fwd, fwd_hold); end
         tick();
      end
      @(negedge clk);
      n_cmp++; if (rs1_fwd !== 32'h44 || fwd_hold !== 1'b0) begin n_bad++; $display("FAIL stall_release got %h/%b exp 44/0", rs1_fwd, fwd_hold); end
      // Load-use bubble overrides hits.
      idle(); stall_ld = 1'b1; h1_idex = 1'b1; rs1_data = 32'h55;
      @(negedge clk);
      n_cmp++; if (rs1_fwd !== 32'h55) begin n_bad++; $display("FAIL stall_ld got %h exp 55", rs1_fwd); end
      tick();
      // Flush during HOLD.
      idle(); rd_wb = 32'h66; tick();
      stall = 1'b1; tick();
      n_cmp++; if (fwd_hold !== 1'b1) begin n_bad++; $display("FAIL flush_pre got %b exp 1", fwd_hold); end
      rst_pipe = 1'b1; tick();
      idle(); h1_idwb = 1'b1;
      @(negedge clk);
      n_cmp++; if (fwd_hold !== 1'b0) begin n_bad++; $display("FAIL flush_hold got %b exp 0", fwd_hold); end
      n_cmp++; if (rs1_fwd !== 32'h0) begin n_bad++; $display("FAIL flush_wbdly got %h exp 0", rs1_fwd); end
      n_cmp++; if (rs2_fwd !== rs2_data) begin n_bad++; $display("FAIL flush_rf got %h exp %h", rs2_fwd, rs2_data); end
      tick();
      idle();
   endtask

   task automatic test_onehot_err();
      idle(); h2_idex = 1'b1; h2_idma = 1'b1;
      @(negedge clk);
      n_cmp++; if (rs2_fwd !== rd_ma) begin n_bad++; $display("FAIL multi_hit_rs2 got %h exp %h", rs2_fwd, rd_ma); end
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         if (i == 1) rst_pipe = 1'b1;
         else rst_pipe = 1'b0;
         @(negedge clk);
         n_cmp++; if (fwd_err !== m_err) begin n_bad++; $display("FAIL err_sticky_%0d got %b exp %b", i, fwd_err, m_err); end
         tick();
      end
      rst_pipe = 1'b0;
      rst_n = 1'b0; #1; model_reset();
      n_cmp++; if (fwd_err !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b exp 0", fwd_err); end
      @(negedge clk); rst_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      logic [3:0] f;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 2; k++) begin
            case ($urandom_range(0, 9))
               0, 1:    f = 4'b1000;
               2, 3:    f = 4'b0100;
               4, 5:    f = 4'b0010;
               6:       f = 4'b0001;
               7:       f = 4'b0000;
               default: f = 4'($urandom_range(0, 15));
            endcase
            if (k == 0) {h1_idex, h1_idma, h1_idwb, n1} = f;
            else        {h2_idex, h2_idma, h2_idwb, n2} = f;
         end
         stall_ld = ($urandom_range(0, 9) == 0);
         stall    = ($urandom_range(0, 9) < 3);
         rst_pipe = ($urandom_range(0, 19) == 0);
         rs1_data = $urandom; rs2_data = $urandom;
         rd_ma    = $urandom; rd_wb    = $urandom;
         @(negedge clk);
         n_cmp++; if (rs1_fwd !== exp1()) begin n_bad++; $display("FAIL rnd_rs1 c%0d got %h exp %h", c, rs1_fwd, exp1()); end
         n_cmp++; if (rs2_fwd !== exp2()) begin n_bad++; $display("FAIL rnd_rs2 c%0d got %h exp %h", c, rs2_fwd, exp2()); end
         n_cmp++; if (fwd_hold !== m_hold) begin n_bad++; $display("FAIL rnd_hold c%0d got %b exp %b", c, fwd_hold, m_hold); end
         n_cmp++; if (fwd_err !== m_err) begin n_bad++; $display("FAIL rnd_err c%0d got %b exp %b", c, fwd_err, m_err); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_onehot_err();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
